// File: rtl/mem_link_pkg.sv
// Shared types for the memory-over-UART receive path: receiver state encoding
// and the bytes-per-word helper.
package mem_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        CHECK,
        DONE
    } rx_state_e;

    function automatic int unsigned BYTES_PER_WORD(input int unsigned word_len,
                                                   input int unsigned byte_len);
        return (word_len + byte_len - 1) / byte_len;
    endfunction

endpackage

// File: rtl/mem_image_receiver_if.sv
// Control, UART-byte and memory-write signals of mem_image_receiver.
// The master side drives start/addresses/bytes; the slave side is the receiver.
interface mem_image_receiver_if #(
    parameter int unsigned MEM_WORD_LENGTH = 12,
    parameter int unsigned MEM_ADDR_LENGTH = 12,
    parameter int unsigned UART_WIDTH      = 8
);
    logic                       start;
    logic [MEM_ADDR_LENGTH-1:0] start_addr;
    logic [MEM_ADDR_LENGTH-1:0] end_addr;
    logic                       rxByteReady;
    logic [UART_WIDTH-1:0]      byteFromRx;
    logic                       memWrEn;
    logic [MEM_ADDR_LENGTH-1:0] mem_address;
    logic [MEM_WORD_LENGTH-1:0] dataToMem;
    logic                       busy;
    logic                       image_received;
    logic                       timeout_err;
    logic                       checksum_err;
    logic [MEM_ADDR_LENGTH:0]   words_written;

    modport master (
        output start, start_addr, end_addr, rxByteReady, byteFromRx,
        input  memWrEn, mem_address, dataToMem, busy, image_received,
               timeout_err, checksum_err, words_written
    );

    modport slave (
        input  start, start_addr, end_addr, rxByteReady, byteFromRx,
        output memWrEn, mem_address, dataToMem, busy, image_received,
               timeout_err, checksum_err, words_written
    );
endinterface

// File: rtl/mem_image_receiver_word_assembler.sv
// Packs LSB-first bytes into a word register; word_c/last_c reflect the
// byte being loaded this cycle so the caller can register the full word.
module word_assembler
    import mem_link_pkg::*;
#(
    parameter int unsigned WORD_W = 12,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              last_c
);
    localparam int unsigned BPW   = BYTES_PER_WORD(WORD_W, BYTE_W);
    localparam int unsigned ASM_W = BPW * BYTE_W;
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

    logic [ASM_W-1:0] asm_q;
    logic [ASM_W-1:0] asm_d;
    logic [IDX_W-1:0] idx_q;

    // Next assembly value with the incoming byte dropped into its slot
    always_comb begin
        asm_d = asm_q;
        if (load) begin
            asm_d[32'(idx_q) * BYTE_W +: BYTE_W] = byte_in;
        end
        last_c = load && (idx_q == IDX_LAST);
        word_c = asm_d[WORD_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            idx_q <= '0;
        end else if (clear) begin
            asm_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            asm_q <= asm_d;
            idx_q <= last_c ? '0 : idx_q + IDX_W'(1);
        end
    end
endmodule

// File: rtl/mem_image_receiver.sv
// Receives a memory image as UART bytes and writes it word by word from start_addr
// to end_addr. Optional trailing XOR checksum byte: define MEM_IMAGE_CHECKSUM_EN.
module mem_image_receiver
    import mem_link_pkg::*;
#(
    parameter int unsigned MEM_WORD_LENGTH = 12,
    parameter int unsigned MEM_DEPTH       = 4096,
    parameter int unsigned MEM_ADDR_LENGTH = $clog2(MEM_DEPTH),
    parameter int unsigned UART_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input logic                 clk,
    input logic                 rst,
    mem_image_receiver_if.slave bus
);
    localparam int unsigned AW      = MEM_ADDR_LENGTH;
    localparam int unsigned CW      = MEM_ADDR_LENGTH + 1;
    localparam int unsigned WW      = MEM_WORD_LENGTH;
    localparam int unsigned BW      = UART_WIDTH;
    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    rx_state_e         state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     end_q, end_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CW-1:0]     written_q, written_d;
    logic [WW-1:0]     data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              tmo_q, tmo_d;
    logic              pend_valid_q, pend_valid_d;
    logic [BW-1:0]     pend_byte_q, pend_byte_d;
`ifdef MEM_IMAGE_CHECKSUM_EN
    logic [BW-1:0]     csum_q, csum_d;
    logic              cerr_q, cerr_d;
`endif

    logic              byte_avail_c;
    logic [BW-1:0]     byte_c;
    logic              asm_clear_c;
    logic              asm_load_c;
    logic [WW-1:0]     asm_word_c;
    logic              asm_last_c;

    // A byte held over from a WRITE cycle is always consumed before a live one
    assign byte_avail_c = pend_valid_q | bus.rxByteReady;
    assign byte_c       = pend_valid_q ? pend_byte_q : bus.byteFromRx;

    word_assembler #(
        .WORD_W (WW),
        .BYTE_W (BW)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear_c),
        .load    (asm_load_c),
        .byte_in (byte_c),
        .word_c  (asm_word_c),
        .last_c  (asm_last_c)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        end_d        = end_q;
        timer_d      = timer_q;
        written_d    = written_q;
        data_d       = data_q;
        wr_en_d      = 1'b0;
        done_d       = 1'b0;
        tmo_d        = tmo_q;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        asm_clear_c  = 1'b0;
        asm_load_c   = 1'b0;
`ifdef MEM_IMAGE_CHECKSUM_EN
        csum_d       = csum_q;
        cerr_d       = cerr_q;
`endif

        case (state_q)
            IDLE: begin
                pend_valid_d = 1'b0;
                if (bus.start) begin
                    addr_d      = bus.start_addr;
                    end_d       = bus.end_addr;
                    timer_d     = '0;
                    written_d   = '0;
                    tmo_d       = 1'b0;
                    asm_clear_c = 1'b1;
`ifdef MEM_IMAGE_CHECKSUM_EN
                    csum_d      = '0;
                    cerr_d      = 1'b0;
`endif
                    state_d     = WAIT_BYTE;
                end
            end

            WAIT_BYTE: begin
                if (byte_avail_c) begin
                    asm_load_c = 1'b1;
                    timer_d    = '0;
`ifdef MEM_IMAGE_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_c;
`endif
                    if (pend_valid_q) begin
                        pend_valid_d = bus.rxByteReady;
                        if (bus.rxByteReady) pend_byte_d = bus.byteFromRx;
                    end
                    if (asm_last_c) begin
                        wr_en_d = 1'b1;
                        data_d  = asm_word_c;
                        state_d = WRITE;
                    end
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT_EN) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            WRITE: begin
                written_d   = written_q + CW'(1);
                asm_clear_c = 1'b1;
                if (bus.rxByteReady) begin
                    pend_valid_d = 1'b1;
                    pend_byte_d  = bus.byteFromRx;
                end
                if (addr_q == end_q) begin
`ifdef MEM_IMAGE_CHECKSUM_EN
                    state_d = CHECK;
`else
                    done_d  = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = WAIT_BYTE;
                end
            end

`ifdef MEM_IMAGE_CHECKSUM_EN
            // Trailing byte must equal the XOR of every data byte
            CHECK: begin
                if (byte_avail_c) begin
                    timer_d = '0;
                    cerr_d  = (byte_c != csum_q);
                    if (pend_valid_q) begin
                        pend_valid_d = bus.rxByteReady;
                        if (bus.rxByteReady) pend_byte_d = bus.byteFromRx;
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else if (TIMEOUT_EN) begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
`endif

            DONE: begin
                pend_valid_d = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            end_q        <= '0;
            timer_q      <= '0;
            written_q    <= '0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            tmo_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= '0;
`ifdef MEM_IMAGE_CHECKSUM_EN
            csum_q       <= '0;
            cerr_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            end_q        <= end_d;
            timer_q      <= timer_d;
            written_q    <= written_d;
            data_q       <= data_d;
            wr_en_q      <= wr_en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            tmo_q        <= tmo_d;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
`ifdef MEM_IMAGE_CHECKSUM_EN
            csum_q       <= csum_d;
            cerr_q       <= cerr_d;
`endif
        end
    end

    assign bus.memWrEn        = wr_en_q;
    assign bus.mem_address    = addr_q;
    assign bus.dataToMem      = data_q;
    assign bus.busy           = busy_q;
    assign bus.image_received = done_q;
    assign bus.timeout_err    = tmo_q;
    assign bus.words_written  = written_q;
`ifdef MEM_IMAGE_CHECKSUM_EN
    assign bus.checksum_err   = cerr_q;
`else
    assign bus.checksum_err   = 1'b0;
`endif
endmodule
